adder_tree_acc: RTL and testbench

- Parametrised successor to the fixed 8x16b adder-tree FSM.
- Reduces N_LANES unsigned lanes per beat through a log2(N_LANES)-stage registered adder tree.
- Accumulates a start-specified number of beats (len) into an ACC_W-bit result, with a valid/ready beat handshake.
- Sits behind the host trigger/pipe interface; start comes from a trigger, done feeds back as a trigger.

---
 rtl/adder_tree_acc_pkg.sv | 30 +++
 rtl/adder_tree_acc_if.sv | 29 ++
 rtl/adder_tree_acc_pipe.sv | 66 ++++++
 rtl/adder_tree_acc.sv | 164 ++++++++++++++++
 tb/tb_adder_tree_acc.sv | 270 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/adder_tree_acc_pkg.sv
// Shared definitions for the adder_tree_acc slice: job states, clog2 helper and default widths.
package adder_tree_pkg;

  localparam int DEF_N_LANES = 32'sd8;
  localparam int DEF_DIN_W   = 32'sd16;
  localparam int DEF_ACC_W   = 32'sd24;
  localparam int DEF_LEN_W   = 32'sd8;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE  = ST_IDLE,
    S_RUN   = ST_RUN,
    S_DRAIN = ST_DRAIN,
    S_DONE  = ST_DONE
  } state_e;

  function automatic int clog2(input int value);
    int result;
    result = 32'sd0;
    while ((32'sd1 << result) < value) begin
      result = result + 32'sd1;
    end
    return result;
  endfunction

endpackage

// File: rtl/adder_tree_acc_if.sv
// Job/beat interface between the host trigger/pipe logic (master) and adder_tree_acc (slave).
interface adder_tree_acc_if
  import adder_tree_pkg::*;
#(
  parameter int N_LANES = DEF_N_LANES,
  parameter int DIN_W   = DEF_DIN_W,
  parameter int ACC_W   = DEF_ACC_W,
  parameter int LEN_W   = DEF_LEN_W
);
  logic                       start;
  logic [LEN_W-1:0]           len;
  logic                       din_valid;
  logic [N_LANES*DIN_W-1:0]   din;
  logic                       din_ready;
  logic                       busy;
  logic                       done;
  logic [ACC_W-1:0]           dout;
  logic                       ovf;

  modport master (
    output start, len, din_valid, din,
    input  din_ready, busy, done, dout, ovf
  );

  modport slave (
    input  start, len, din_valid, din,
    output din_ready, busy, done, dout, ovf
  );
endinterface

// File: rtl/adder_tree_acc_pipe.sv
// adder_tree_pipe: valid-tagged registered adder tree, one stage per level, each level one bit wider.
module adder_tree_pipe
  import adder_tree_pkg::*;
#(
  parameter  int N_LANES = DEF_N_LANES,
  parameter  int DIN_W   = DEF_DIN_W,
  localparam int LOG2N   = clog2(N_LANES)
) (
  input  logic                       clk,
  input  logic                       rstn,
  input  logic                       in_valid,
  input  logic [N_LANES*DIN_W-1:0]   in_data,
  output logic                       out_valid,
  output logic [DIN_W+LOG2N-1:0]     out_sum,
  output logic                       active
);
  logic [LOG2N:1] valid_vec_s;

  genvar k, j;
  for (k = 1; k <= LOG2N; k++) begin : g_stage
    localparam int W   = DIN_W + k;
    localparam int CNT = N_LANES >> k;

    logic [W-1:0] sum_s [CNT];
    logic [W-1:0] sum_r [CNT];
    logic         valid_in_s;
    logic         valid_r;

    if (k == 1) begin : g_first
      for (j = 0; j < CNT; j++) begin : g_pair
        assign sum_s[j] = {1'b0, in_data[(2*j)*DIN_W +: DIN_W]}
                        + {1'b0, in_data[(2*j+1)*DIN_W +: DIN_W]};
      end
      assign valid_in_s = in_valid;
    end else begin : g_next
      for (j = 0; j < CNT; j++) begin : g_pair
        assign sum_s[j] = {1'b0, g_stage[k-1].sum_r[2*j]}
                        + {1'b0, g_stage[k-1].sum_r[2*j+1]};
      end
      assign valid_in_s = g_stage[k-1].valid_r;
    end

    // Stage register: sums only load when a valid beat arrives, the tag follows every edge
    always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
        valid_r <= 1'b0;
        for (int i = 0; i < CNT; i++) begin
          sum_r[i] <= {W{1'b0}};
        end
      end else begin
        valid_r <= valid_in_s;
        if (valid_in_s) begin
          for (int i = 0; i < CNT; i++) begin
            sum_r[i] <= sum_s[i];
          end
        end
      end
    end

    assign valid_vec_s[k] = valid_r;
  end

  assign out_sum   = g_stage[LOG2N].sum_r[0];
  assign out_valid = g_stage[LOG2N].valid_r;
  assign active    = |valid_vec_s;
endmodule

// File: rtl/adder_tree_acc.sv
// adder_tree_acc: job FSM, beat counter and accumulator around adder_tree_pipe.
// Define ADDER_TREE_ACC_SAT_EN to clamp the accumulator on carry-out and raise a sticky ovf.
module adder_tree_acc
  import adder_tree_pkg::*;
#(
  parameter int N_LANES = DEF_N_LANES,
  parameter int DIN_W   = DEF_DIN_W,
  parameter int ACC_W   = DEF_ACC_W,
  parameter int LEN_W   = DEF_LEN_W
) (
  input  logic               clk,
  input  logic               rstn,
  adder_tree_acc_if.slave    bus
);
  localparam int LOG2N  = clog2(N_LANES);
  localparam int TREE_W = DIN_W + LOG2N;
`ifdef ADDER_TREE_ACC_SAT_EN
  localparam int SUM_W  = ACC_W + 1;
`else
  localparam int SUM_W  = ACC_W;
`endif
  localparam logic [LEN_W-1:0] LEN_ZERO = {LEN_W{1'b0}};
  localparam logic [LEN_W-1:0] LEN_ONE  = {{(LEN_W-1){1'b0}}, 1'b1};

  state_e             state_r, state_s;
  logic [LEN_W-1:0]   cnt_r;
  logic [ACC_W-1:0]   acc_r;
  logic [ACC_W-1:0]   dout_r;
  logic               din_ready_r, busy_r, done_r;
  logic               accept_s, start_ok_s;
  logic               tree_valid_s, tree_active_s;
  logic [TREE_W-1:0]  tree_sum_s;
  logic [SUM_W-1:0]   acc_sum_s;

  assign accept_s   = bus.din_valid & din_ready_r;
  assign start_ok_s = bus.start & (state_r == S_IDLE);
  assign acc_sum_s  = SUM_W'(acc_r) + SUM_W'(tree_sum_s);

  adder_tree_pipe #(
    .N_LANES (N_LANES),
    .DIN_W   (DIN_W)
  ) u_pipe (
    .clk       (clk),
    .rstn      (rstn),
    .in_valid  (accept_s),
    .in_data   (bus.din),
    .out_valid (tree_valid_s),
    .out_sum   (tree_sum_s),
    .active    (tree_active_s)
  );

  // Next-state logic; DRAIN waits until no tagged sum remains in the tree
  always_comb begin
    state_s = state_r;
    case (state_r)
      S_IDLE: begin
        if (bus.start) begin
          if (bus.len == LEN_ZERO) begin
            state_s = S_DONE;
          end else begin
            state_s = S_RUN;
          end
        end else begin
          state_s = S_IDLE;
        end
      end
      S_RUN: begin
        if (accept_s && (cnt_r == LEN_ONE)) begin
          state_s = S_DRAIN;
        end else begin
          state_s = S_RUN;
        end
      end
      S_DRAIN: begin
        if (!tree_active_s) begin
          state_s = S_DONE;
        end else begin
          state_s = S_DRAIN;
        end
      end
      S_DONE:  state_s = S_IDLE;
      default: state_s = S_IDLE;
    endcase
  end

  // State register with status outputs registered from the next state
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_r     <= S_IDLE;
      din_ready_r <= 1'b0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
    end else begin
      state_r     <= state_s;
      din_ready_r <= (state_s == S_RUN);
      busy_r      <= (state_s != S_IDLE);
      done_r      <= (state_s == S_DONE);
    end
  end

  // Remaining-beat counter
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt_r <= LEN_ZERO;
    end else if (start_ok_s) begin
      cnt_r <= bus.len;
    end else if (accept_s) begin
      cnt_r <= cnt_r - LEN_ONE;
    end
  end

`ifdef ADDER_TREE_ACC_SAT_EN
  logic ovf_r;

  // Accumulator clamps at all-ones once any add carries out, and stays clamped for the job
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      acc_r <= {ACC_W{1'b0}};
      ovf_r <= 1'b0;
    end else if (start_ok_s) begin
      acc_r <= {ACC_W{1'b0}};
      ovf_r <= 1'b0;
    end else if (tree_valid_s) begin
      if (ovf_r || acc_sum_s[ACC_W]) begin
        acc_r <= {ACC_W{1'b1}};
        ovf_r <= 1'b1;
      end else begin
        acc_r <= acc_sum_s[ACC_W-1:0];
      end
    end
  end

  assign bus.ovf = ovf_r;
`else
  // Accumulator wraps modulo 2^ACC_W
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      acc_r <= {ACC_W{1'b0}};
    end else if (start_ok_s) begin
      acc_r <= {ACC_W{1'b0}};
    end else if (tree_valid_s) begin
      acc_r <= acc_sum_s;
    end
  end

  assign bus.ovf = 1'b0;
`endif

  // Result register: zero for an empty job, otherwise captured as the drain completes
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      dout_r <= {ACC_W{1'b0}};
    end else if (start_ok_s && (bus.len == LEN_ZERO)) begin
      dout_r <= {ACC_W{1'b0}};
    end else if ((state_r == S_DRAIN) && !tree_active_s) begin
      dout_r <= acc_r;
    end
  end

  assign bus.din_ready = din_ready_r;
  assign bus.busy      = busy_r;
  assign bus.done      = done_r;
  assign bus.dout      = dout_r;
endmodule

// File: tb/tb_adder_tree_acc.sv
// Directed bench for adder_tree_acc: job-level reference model checked every cycle plus literal results.
module tb_adder_tree_acc;
  localparam int N_LANES = 8;
  localparam int DIN_W   = 16;
  localparam int ACC_W   = 24;
  localparam int LEN_W   = 8;
  localparam int LOG2N   = 3;
  localparam longint ACC_MAX = (64'sd1 <<< ACC_W) - 64'sd1;
`ifdef ADDER_TREE_ACC_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  adder_tree_acc_if #(.N_LANES(N_LANES), .DIN_W(DIN_W), .ACC_W(ACC_W), .LEN_W(LEN_W)) bus ();

  adder_tree_acc #(.N_LANES(N_LANES), .DIN_W(DIN_W), .ACC_W(ACC_W), .LEN_W(LEN_W)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int last_acc_cyc = 0;
  bit cmp_en   = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
    end
  endtask

  // ---------------- job-level reference model ----------------
  typedef enum {P_IDLE, P_RUN, P_WAIT, P_DONE} phase_e;
  phase_e           m_phase = P_IDLE;
  int               m_left  = 0;
  int               m_wait  = 0;
  longint           m_total = 0;
  logic [ACC_W-1:0] m_dout  = '0;
  logic             m_ovf   = 1'b0;

  function automatic longint lane_total(input logic [N_LANES*DIN_W-1:0] d);
    longint s = 0;
    for (int i = 0; i < N_LANES; i++) s += longint'(d[i*DIN_W +: DIN_W]);
    return s;
  endfunction

  function automatic longint fold(input longint t);
    if (SAT) return (t > ACC_MAX) ? ACC_MAX : t;
    return t % (ACC_MAX + 1);
  endfunction

  // Result is total of all lanes of all beats; done lands LOG2N+1 edges after the last beat
  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      m_phase = P_IDLE; m_left = 0; m_wait = 0; m_total = 0; m_dout = '0; m_ovf = 1'b0;
    end else begin
      case (m_phase)
        P_IDLE: if (bus.start) begin
          m_total = 0;
          m_ovf   = 1'b0;
          if (bus.len == 0) begin
            m_phase = P_DONE;
            m_dout  = '0;
          end else begin
            m_left  = int'(bus.len);
            m_phase = P_RUN;
          end
        end
        P_RUN: if (bus.din_valid) begin
          m_total += lane_total(bus.din);
          m_left--;
          if (m_left == 0) begin
            m_phase = P_WAIT;
            m_wait  = LOG2N + 1;
          end
        end
        P_WAIT: begin
          m_wait--;
          if (m_wait == 0) begin
            m_phase = P_DONE;
            m_dout  = ACC_W'(fold(m_total));
            m_ovf   = SAT && (m_total > ACC_MAX);
          end
        end
        default: m_phase = P_IDLE;
      endcase
    end
  end

  // Per-cycle comparison against the model, sampled mid-cycle
  always @(negedge clk) begin
    if (cmp_en) begin
      check("busy",      bus.busy,      m_phase != P_IDLE);
      check("din_ready", bus.din_ready, m_phase == P_RUN);
      check("done",      bus.done,      m_phase == P_DONE);
      check("dout",      bus.dout,      m_dout);
      if (!SAT || m_phase == P_IDLE || m_phase == P_DONE)
        check("ovf", bus.ovf, m_ovf);
    end
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic start_job(input int l);
    bus.start = 1'b1;
    bus.len   = l[LEN_W-1:0];
    step();
    bus.start = 1'b0;
    bus.len   = '0;
  endtask

  task automatic send_beat(input logic [N_LANES*DIN_W-1:0] d);
    bit got = 1'b0;
    bus.din       = d;
    bus.din_valid = 1'b1;
    for (int i = 0; i < 50 && !got; i++) begin
      if (bus.din_ready) got = 1'b1;
      step();
    end
    check("beat_accepted", got, 1'b1);
    last_acc_cyc = cyc;
  endtask

  task automatic wait_done(output int lat);
    bit seen = 1'b0;
    for (int i = 0; i < 200 && !seen; i++) begin
      if (bus.done) seen = 1'b1;
      else step();
    end
    check("done_seen", seen, 1'b1);
    lat = cyc - last_acc_cyc;
  endtask

  function automatic logic [N_LANES*DIN_W-1:0] lanes_seq();
    logic [N_LANES*DIN_W-1:0] d;
    for (int i = 0; i < N_LANES; i++) d[i*DIN_W +: DIN_W] = DIN_W'(i + 1);
    return d;
  endfunction

  function automatic logic [N_LANES*DIN_W-1:0] lanes_all(input logic [DIN_W-1:0] v);
    logic [N_LANES*DIN_W-1:0] d;
    for (int i = 0; i < N_LANES; i++) d[i*DIN_W +: DIN_W] = v;
    return d;
  endfunction

  initial begin
    int lat;
    bus.start = 1'b0; bus.len = '0; bus.din_valid = 1'b0; bus.din = '0;
    rstn = 1'b0;
    step();
    cmp_en = 1'b1;
    check("reset_dout", bus.dout, 0);
    check("reset_busy", bus.busy, 0);
    check("reset_ready", bus.din_ready, 0);
    step();
    rstn = 1'b1;
    step();

    // single beat, lanes 1..8
    start_job(1);
    send_beat(lanes_seq());
    bus.din_valid = 1'b0;
    wait_done(lat);
    check("single_latency", lat, 4);
    check("single_dout", bus.dout, 36);
    step();
    check("single_busy_after", bus.busy, 0);

    // back-to-back saturated lanes, valid held high
    start_job(3);
    for (int b = 0; b < 3; b++) send_beat(lanes_all(16'hFFFF));
    bus.din_valid = 1'b0;
    wait_done(lat);
    check("b2b_dout", bus.dout, 1572840);
    check("b2b_ovf", bus.ovf, 0);
    step();

    // bubbles between beats
    start_job(2);
    send_beat(lanes_all(16'd1));
    bus.din_valid = 1'b0;
    for (int g = 0; g < 3; g++) begin
      check("bubble_ready", bus.din_ready, 1);
      step();
    end
    send_beat(lanes_all(16'd2));
    bus.din_valid = 1'b0;
    wait_done(lat);
    check("bubble_dout", bus.dout, 24);
    step();

    // zero length
    bus.din_valid = 1'b1;
    start_job(0);
    bus.din_valid = 1'b0;
    check("zero_done", bus.done, 1);
    check("zero_dout", bus.dout, 0);
    step();
    check("zero_busy_after", bus.busy, 0);

    // 40 beats of 0xFFFF: wraps or saturates
    start_job(40);
    for (int b = 0; b < 40; b++) send_beat(lanes_all(16'hFFFF));
    bus.din_valid = 1'b0;
    wait_done(lat);
    check("ovf_latency", lat, 4);
    check("ovf_dout", bus.dout, SAT ? 64'd16777215 : 64'd4193984);
    check("ovf_flag", bus.ovf, SAT ? 1 : 0);
    step();
    step();
    check("ovf_sticky_idle", bus.ovf, SAT ? 1 : 0);

    // start pulses during RUN and DRAIN are ignored
    start_job(3);
    for (int b = 0; b < 3; b++) begin
      bus.start = 1'b1;
      bus.len   = 8'd0;
      send_beat(lanes_all(16'd1));
    end
    bus.din_valid = 1'b0;
    step();
    bus.start = 1'b0;
    wait_done(lat);
    check("abuse_dout", bus.dout, 24);
    check("abuse_ovf_cleared", bus.ovf, 0);
    step();

    // reset mid-job
    start_job(5);
    send_beat(lanes_seq());
    send_beat(lanes_seq());
    bus.din_valid = 1'b0;
    rstn = 1'b0;
    #2;
    check("rst_busy", bus.busy, 0);
    check("rst_done", bus.done, 0);
    check("rst_dout", bus.dout, 0);
    step();
    step();
    rstn = 1'b1;
    step();
    start_job(1);
    send_beat(lanes_seq());
    bus.din_valid = 1'b0;
    wait_done(lat);
    check("post_rst_latency", lat, 4);
    check("post_rst_dout", bus.dout, 36);
    step();
    step();

    cmp_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
